// File: rtl/aitl_pkg.sv
// Mode codes, debounce state and zone classifier shared by the sensor path and the control top.
// Purely combinational helpers; no latency.
// No flow control here; consumers own their handshakes.
package aitl_pkg;

  // Command encoding understood by the control top FSM.
  localparam logic [1:0] MODE_HOLD     = 2'd0;
  localparam logic [1:0] MODE_TRACK    = 2'd1;
  localparam logic [1:0] MODE_RECOVERY = 2'd2;
  localparam logic [1:0] MODE_IDLE     = 2'd3;

  // Debounce FSM state.
  typedef logic [0:0] dbnc_state_t;
  localparam dbnc_state_t DB_STABLE  = 1'b0;
  localparam dbnc_state_t DB_PENDING = 1'b1;

  // Map an average onto a zone. The committed command widens the band it is
  // sitting in (or the band it must climb into) by the hysteresis margin.
  function automatic logic [1:0] classify_zone(input int a, input logic [1:0] c,
                                               input int lo, input int hi, input int hy);
    logic [1:0] z;
    if (a < lo)       z = MODE_RECOVERY;
    else if (a >= hi) z = MODE_IDLE;
    else              z = MODE_TRACK;
    case (c)
      MODE_TRACK: begin
        if (a < lo - hy)       z = MODE_RECOVERY;
        else if (a >= hi + hy) z = MODE_IDLE;
        else                   z = MODE_TRACK;
      end
      MODE_RECOVERY: begin
        if (a >= lo + hy && a < hi) z = MODE_TRACK;
        else if (a >= hi)           z = MODE_IDLE;
        else                        z = MODE_RECOVERY;
      end
      MODE_IDLE: begin
        if (a >= lo && a < hi - hy) z = MODE_TRACK;
        else if (a < lo)            z = MODE_RECOVERY;
        else                        z = MODE_IDLE;
      end
      default: ;
    endcase
    return z;
  endfunction

endpackage

// File: rtl/aitl_sensor_conditioner_avg.sv
// Power-of-two moving average over a circular sample window with warm-up and flush.
// Sample accepted at edge N -> avg_data/avg_valid registered at edge N+1.
// No backpressure: one sample per cycle always accepted; flush drops a colliding sample.
module aitl_moving_avg import aitl_pkg::*; #(
  parameter int DATA_W   = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              flush,
  output logic [DATA_W-1:0] avg_data,
  output logic              avg_valid
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SUM_W  = DATA_W + AVG_LOG2;
  localparam int FILL_W = AVG_LOG2 + 1;

  logic [DATA_W-1:0]   win [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [FILL_W-1:0]   fill;
  logic [SUM_W-1:0]    sum;
  logic [SUM_W-1:0]    sum_nxt;
  logic                full_upd;

  // Slots not yet written hold zero, so the same add/evict works during warm-up.
  // Intermediate wrap is harmless: the true result always fits in SUM_W.
  assign sum_nxt = sum + SUM_W'(sample_data) - SUM_W'(win[wr_ptr]);

  // Window, running sum, pointer and fill level; flush returns to warm-up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
      wr_ptr   <= '0;
      fill     <= '0;
      sum      <= '0;
      full_upd <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
      wr_ptr   <= '0;
      fill     <= '0;
      sum      <= '0;
      full_upd <= 1'b0;
    end else if (sample_valid) begin
      win[wr_ptr] <= sample_data;
      wr_ptr      <= wr_ptr + AVG_LOG2'(1);
      sum         <= sum_nxt;
      if (fill != FILL_W'(DEPTH)) fill <= fill + FILL_W'(1);
      full_upd    <= (fill >= FILL_W'(DEPTH - 1));
    end else begin
      full_upd <= 1'b0;
    end
  end

  // Publish the truncated average one edge after the sum settles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      avg_data  <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= full_upd;
      if (full_upd) avg_data <= DATA_W'(sum >> AVG_LOG2);
    end
  end

endmodule

// File: rtl/aitl_sensor_conditioner.sv
// Sensor front-end: moving average, then zone classification with hysteresis and debounce.
// Average at sample edge N+1; cmd_out/cmd_strobe at edge N+2 of the committing average.
// No backpressure: full-rate samples; outputs are single-cycle pulses with no ready.
module aitl_sensor_conditioner import aitl_pkg::*; #(
  parameter int DATA_W   = 8,
  parameter int AVG_LOG2 = 2,
  parameter int TH_LOW   = 75,
  parameter int TH_HIGH  = 88,
  parameter int HYST     = 2,
  parameter int DEBOUNCE = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              flush,
  output logic [DATA_W-1:0] sensor_out,
  output logic              out_valid,
  output logic [1:0]        cmd_out,
  output logic              cmd_strobe
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  dbnc_state_t      state;
  logic [1:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       zone;

  aitl_moving_avg #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .flush        (flush),
    .avg_data     (sensor_out),
    .avg_valid    (out_valid)
  );

  assign zone = classify_zone(int'(sensor_out), cmd_out, TH_LOW, TH_HIGH, HYST);

  // Debounce: a new zone must persist for DEBOUNCE consecutive averages before it commits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= DB_STABLE;
      cand       <= MODE_HOLD;
      cnt        <= '0;
      cmd_out    <= MODE_HOLD;
      cmd_strobe <= 1'b0;
    end else begin
      cmd_strobe <= 1'b0;
      if (out_valid) begin
        if (zone == cmd_out) begin
          state <= DB_STABLE;
          cnt   <= '0;
        end else if (state == DB_PENDING && zone == cand) begin
          if (cnt + CNT_W'(1) == CNT_W'(DEBOUNCE)) begin
            cmd_out    <= cand;
            cmd_strobe <= 1'b1;
            state      <= DB_STABLE;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end else begin
          cand <= zone;
          if (DEBOUNCE == 1) begin
            cmd_out    <= zone;
            cmd_strobe <= 1'b1;
            state      <= DB_STABLE;
            cnt        <= '0;
          end else begin
            cnt   <= CNT_W'(1);
            state <= DB_PENDING;
          end
        end
      end
    end
  end

endmodule
